// File: rtl/spi_transaction_fsm.sv
// SPI mode-0 address/RW + data transaction decoder driving a sync-read memory.
// Define SPI_BURST_AUTOINC_EN for auto-incrementing multi-word bursts.
module spi_transaction_fsm #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              sclk_rise,
  input  logic              sclk_fall,
  input  logic              mosi,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_dout,
  output logic              miso,
  output logic              miso_en,
  output logic              busy
);

  localparam int AW1   = ADDR_W + 1;
  localparam int RX_W  = (AW1 > DATA_W) ? AW1 : DATA_W;
  localparam int CNT_W = $clog2(RX_W + 1);

  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(AW1 - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] D_END  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    READ_WAIT,
    READ_LOAD,
    READ_SEND,
    WRITE_GET,
    WRITE_COMMIT,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RX_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              men_q, men_d;
  logic [RX_W-1:0]   rx_sh;

  assign rx_sh = {rx_q[RX_W-2:0], mosi};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      men_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      men_q   <= men_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    men_d   = men_q;
    // chip-select release beats any same-cycle SCLK edge
    if (state_q != IDLE && cs_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      men_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!cs_n) begin
            state_d = ADDR;
            cnt_d   = '0;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            rx_d = rx_sh;
            if (cnt_q == A_LAST) begin
              addr_d  = rx_sh[ADDR_W:1];
              cnt_d   = '0;
              state_d = rx_sh[0] ? READ_WAIT : WRITE_GET;
            end else begin
              cnt_d = cnt_q + C_ONE;
            end
          end
        end
        READ_WAIT: state_d = READ_LOAD;
        READ_LOAD: begin
          tx_d    = dm_dout;
          men_d   = 1'b1;
          state_d = READ_SEND;
        end
        READ_SEND: begin
          if (sclk_rise) begin
            if (cnt_q == D_LAST) begin
              cnt_d = '0;
`ifdef SPI_BURST_AUTOINC_EN
              addr_d  = addr_q + A_ONE;
              state_d = READ_WAIT;
`else
              men_d   = 1'b0;
              state_d = DONE;
`endif
            end else begin
              cnt_d = cnt_q + C_ONE;
            end
          end else if (sclk_fall && cnt_q != '0
                       && cnt_q < D_END) begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
        WRITE_GET: begin
          if (sclk_rise) begin
            rx_d = rx_sh;
            if (cnt_q == D_LAST) begin
              cnt_d   = '0;
              state_d = WRITE_COMMIT;
            end else begin
              cnt_d = cnt_q + C_ONE;
            end
          end
        end
        WRITE_COMMIT: begin
`ifdef SPI_BURST_AUTOINC_EN
          addr_d  = addr_q + A_ONE;
          state_d = WRITE_GET;
`else
          state_d = DONE;
`endif
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign dm_we   = (state_q == WRITE_COMMIT);
  assign dm_addr = addr_q;
  assign dm_din  = rx_q[DATA_W-1:0];
  assign miso_en = men_q;
  assign miso    = men_q & tx_q[DATA_W-1];
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Directed bench for spi_transaction_fsm with a write/read scoreboard
// and a behavioural synchronous-read memory.
module tb_spi_transaction_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       mosi;
  logic [6:0] dm_addr;
  logic [7:0] dm_din;
  logic       dm_we;
  logic [7:0] dm_dout;
  logic       miso;
  logic       miso_en;
  logic       busy;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t  wq[$];
  logic rq[$];
  logic [7:0] mem [0:127];
  int n_chk  = 0;
  int n_fail = 0;
  int we_cnt = 0;

  always #5 clk = ~clk;

  spi_transaction_fsm #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .mosi(mosi), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_we(dm_we), .dm_dout(dm_dout), .miso(miso),
    .miso_en(miso_en), .busy(busy)
  );

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_din;
    dm_dout <= mem[dm_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && dm_we === 1'b1) begin
      wr_t e;
      we_cnt++;
      if (wq.size() == 0) begin
        chk("we_unexpected", 32'(wq.size()), 32'd1);
      end else begin
        e = wq.pop_front();
        chk("we_addr", 32'(dm_addr), 32'(e.a));
        chk("we_data", 32'(dm_din), 32'(e.d));
      end
    end
  end

  task automatic gap();
    repeat (3) @(negedge clk);
  endtask

  task automatic rise(input logic b);
    @(negedge clk);
    mosi = b;
    sclk_rise = 1'b1;
    @(negedge clk);
    sclk_rise = 1'b0;
  endtask

  task automatic fall();
    @(negedge clk);
    sclk_fall = 1'b1;
    @(negedge clk);
    sclk_fall = 1'b0;
    gap();
  endtask

  task automatic send_bit(input logic b);
    rise(b);
    gap();
    fall();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic read_bit(input string tag);
    logic e;
    @(negedge clk);
    if (rq.size() == 0) begin
      chk({tag, "_underrun"}, 32'(rq.size()), 32'd1);
    end else begin
      e = rq.pop_front();
      chk(tag, 32'(miso), 32'(e));
    end
    mosi = 1'b0;
    sclk_rise = 1'b1;
    @(negedge clk);
    sclk_rise = 1'b0;
    gap();
    fall();
  endtask

  task automatic start_read(input logic [6:0] a);
    logic [7:0] v;
    v = {a, 1'b1};
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    rise(v[0]);
    chk("miso_en_lat1", 32'(miso_en), 32'd0);
    @(negedge clk);
    chk("miso_en_lat2", 32'(miso_en), 32'd0);
    @(negedge clk);
    chk("miso_en_lat3", 32'(miso_en), 32'd1);
    fall();
  endtask

  task automatic end_txn(input string tag);
    @(negedge clk);
    cs_n = 1'b1;
    #1 chk({tag, "_busy_hold"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    reset = 1'b1;
    cs_n = 1'b1;
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
    mosi = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_miso_en", 32'(miso_en), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_addr", 32'(dm_addr), 32'd0);
    chk("rst_din", 32'(dm_din), 32'd0);
    chk("rst_we", 32'(dm_we), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single write 0x15 <- 0xA5
    cs_n = 1'b0;
    wq.push_back('{a: 7'h15, d: 8'hA5});
    send_byte({7'h15, 1'b0});
    fall();
    send_byte(8'hA5);
    chk("wr_we_cnt", 32'(we_cnt), 32'd1);
    end_txn("wr");

    // single read of 0x15
    @(negedge clk);
    cs_n = 1'b0;
    start_read(7'h15);
    rd = 8'hA5;
    for (int i = 7; i >= 0; i--) rq.push_back(rd[i]);
    for (int i = 0; i < 8; i++) read_bit("rd_bit");
    chk("rd_miso_en_off", 32'(miso_en), 32'd0);
    chk("rd_miso_off", 32'(miso), 32'd0);
    end_txn("rd");

    // write aborted after 4 data bits
    @(negedge clk);
    cs_n = 1'b0;
    send_byte({7'h33, 1'b0});
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_no_we", 32'(we_cnt), 32'd1);
    @(negedge clk);
    cs_n = 1'b0;
    wq.push_back('{a: 7'h01, d: 8'h3C});
    send_byte({7'h01, 1'b0});
    send_byte(8'h3C);
    chk("abort_new_we", 32'(we_cnt), 32'd2);
    end_txn("abw");

    // reset in the middle of a read of 0x01 (0x3C)
    @(negedge clk);
    cs_n = 1'b0;
    start_read(7'h01);
    rq.push_back(1'b0);
    rq.push_back(1'b0);
    read_bit("rr_bit");
    read_bit("rr_bit");
    chk("rr_pre_en", 32'(miso_en), 32'd1);
    chk("rr_pre_addr", 32'(dm_addr), 32'h01);
    #2 reset = 1'b1;
    #1;
    chk("rr_miso_en", 32'(miso_en), 32'd0);
    chk("rr_miso", 32'(miso), 32'd0);
    chk("rr_addr", 32'(dm_addr), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    cs_n = 1'b1;
    reset = 1'b0;
    @(negedge clk);

    // burst write at 0x7F, with stray falls in the address phase
    cs_n = 1'b0;
    wq.push_back('{a: 7'h7F, d: 8'h11});
`ifdef SPI_BURST_AUTOINC_EN
    wq.push_back('{a: 7'h00, d: 8'h22});
`endif
    send_bit(1'b1);
    fall();
    fall();
    for (int i = 5; i >= 0; i--) send_bit(1'b1);
    send_bit(1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
`ifdef SPI_BURST_AUTOINC_EN
    chk("burst_we_cnt", 32'(we_cnt), 32'd4);
`else
    chk("burst_we_cnt", 32'(we_cnt), 32'd3);
`endif
    end_txn("bw");
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
